tick_debouncer: RTL and testbench

//   Debounces one raw mechanical input (button/switch) using a periodic one-cycle

---
 rtl/tick_debouncer.sv | 73 +++++++
 tb/tb_tick_debouncer.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tick_debouncer.sv
// tick_debouncer: two-flop synchronizer plus tick-counted debounce FSM with registered level and edge pulses
module tick_debouncer #(
    parameter int N_TICKS = 3,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic sw_raw,
    output logic db_level,
    output logic db_rise,
    output logic db_fall
);
    typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(N_TICKS - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic s1_q, sw_s_q;
    logic level_q, level_d, rise_q, rise_d, fall_q, fall_d;
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            ZERO: if (sw_s_q) begin
                state_d = WAIT1;
                cnt_d   = CNT_INIT;
            end
            // an abort on sw_s takes priority over a coincident tick
            WAIT1: if (!sw_s_q) state_d = ZERO;
                else if (tick && cnt_q == '0) begin
                    state_d = ONE;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else if (tick) cnt_d = cnt_q - 1'b1;
            ONE: if (!sw_s_q) begin
                state_d = WAIT0;
                cnt_d   = CNT_INIT;
            end
            WAIT0: if (sw_s_q) state_d = ONE;
                else if (tick && cnt_q == '0) begin
                    state_d = ZERO;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else if (tick) cnt_d = cnt_q - 1'b1;
            default: state_d = ZERO;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_q    <= 1'b0;
            sw_s_q  <= 1'b0;
            state_q <= ZERO;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            s1_q    <= sw_raw;
            sw_s_q  <= s1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end
    assign db_level = level_q;
    assign db_rise  = rise_q;
    assign db_fall  = fall_q;
endmodule

// File: tb/tb_tick_debouncer.sv
// tb_tick_debouncer: randomized and directed stimulus; a run-length debounce model predicts pulses,
// and a negedge monitor pops and compares them against what the DUT emits.
module tb_tick_debouncer;
    localparam int N = 3;
    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, sw_raw = 1'b0;
    logic db_level, db_rise, db_fall;
    int checks = 0, errors = 0, cyc = 0, tick_ph = 0;
    bit tick_cont = 1'b0;
    typedef struct {bit rise; int at;} ev_t;
    ev_t exp_q[$];
    bit raw_hist[$];
    bit m_level, m_pending, exp_level;
    int m_ticks;

    tick_debouncer #(.N_TICKS(N), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .tick(tick), .sw_raw(sw_raw),
        .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic model_reset();
        m_level = 1'b0;
        m_pending = 1'b0;
        m_ticks = 0;
        exp_level = 1'b0;
        raw_hist = '{1'b0, 1'b0};
    endtask

    // the level flips once the synced input has disagreed with it for N ticks after the first disagreeing cycle
    task automatic model_step();
        bit s;
        s = raw_hist.pop_front();
        raw_hist.push_back(sw_raw);
        if (s == m_level) m_pending = 1'b0;
        else if (!m_pending) begin
            m_pending = 1'b1;
            m_ticks = 0;
        end else if (tick) begin
            m_ticks++;
            if (m_ticks == N) begin
                m_level = !m_level;
                m_pending = 1'b0;
                exp_q.push_back('{rise: m_level, at: cyc + 1});
            end
        end
    endtask

    task automatic cycle(input bit sw);
        @(posedge clk);
        #2;
        exp_level = m_level;
        sw_raw = sw;
        tick = tick_cont || (tick_ph == 0);
        tick_ph = (tick_ph + 1) % 10;
        if (rst) model_step();
    endtask

    task automatic hold(input bit sw, input int n);
        repeat (n) cycle(sw);
    endtask

    task automatic reset_pulse(input int n, input bit sw);
        @(negedge clk);
        #1 rst = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("reset_level", db_level, 0);
        check("reset_rise", db_rise, 0);
        check("reset_fall", db_fall, 0);
        hold(sw, n);
        rst = 1'b1;
        model_step();
    endtask

    always @(negedge clk) begin
        ev_t ev;
        check("db_level", db_level, exp_level);
        check("rise_fall_exclusive", db_rise & db_fall, 0);
        while (exp_q.size() > 0 && exp_q[0].at < cyc) begin
            ev = exp_q.pop_front();
            check("pulse_missing_at_cycle", 0, ev.at);
        end
        if (db_rise || db_fall) begin
            if (exp_q.size() == 0) check("unexpected_pulse_rise", db_rise, -1);
            else begin
                ev = exp_q.pop_front();
                check("pulse_kind_rise", db_rise, ev.rise);
                check("pulse_cycle", cyc, ev.at);
            end
        end
    end

    initial begin
        model_reset();
        #1 rst = 1'b0;
        hold(1'b0, 3);
        rst = 1'b1;
        model_step();
        hold(1'b1, 60);
        hold(1'b0, 60);
        hold(1'b1, 60);
        hold(1'b0, 4);
        hold(1'b1, 40);
        check("glitch_keeps_level", db_level, 1);
        reset_pulse(8, 1'b1);
        hold(1'b1, 50);
        hold(1'b0, 50);
        for (int i = 0; i < 20; i++) hold(i[0] ? 1'b0 : 1'b1, 3);
        hold(1'b1, 50);
        hold(1'b0, 50);
        begin
            int i;
            for (i = 0; i < 100 && !(m_pending && m_ticks == 1); i++) cycle(1'b1);
            check("reach_wait1_cnt1", i < 100, 1);
        end
        reset_pulse(3, 1'b1);
        hold(1'b1, 50);
        hold(1'b0, 50);
        for (int len = 15; len <= 35; len++) begin
            hold(1'b1, len);
            hold(1'b0, 45);
        end
        tick_cont = 1'b1;
        hold(1'b1, 10);
        hold(1'b0, 2);
        hold(1'b1, 10);
        hold(1'b0, 10);
        tick_cont = 1'b0;
        repeat (150) begin
            if ($urandom_range(0, 29) == 0) reset_pulse($urandom_range(1, 5), 1'($urandom_range(0, 1)));
            tick_cont = ($urandom_range(0, 19) == 0);
            hold(1'($urandom_range(0, 1)), $urandom_range(1, 40));
        end
        tick_cont = 1'b0;
        hold(1'b0, 60);
        check("expected_queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
